// File: rtl/argmax_unit.sv
// Classifier back end: scans NUM_CLASSES signed logits from a sync-read RAM
// and reports the arg-max; define ARGMAX_MARGIN_EN to also report max minus runner-up.
module argmax_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en,
  output logic [IDX_W-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  done_pulse,
  output logic [IDX_W-1:0]      class_idx,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [DATA_WIDTH:0]   margin
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  state_t state_q, state_d;
  logic rd_en_q, rd_en_d;
  logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic done_pulse_q, done_pulse_d;
  logic vld_q, vld_d;
  logic [IDX_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic signed [DATA_WIDTH-1:0] sample;
  logic new_max;

  assign sample  = $signed(rd_data);
  // first sample of a scan always wins; later ones need a strict signed win
  assign new_max = vld_q && ((tag_q == '0) || (sample > max_q));

  // next-state, read sequencing and running maximum
  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    rd_addr_d    = rd_addr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    done_pulse_d = 1'b0;
    vld_d        = rd_en_q;
    tag_d        = rd_addr_q;
    idx_d        = idx_q;
    max_d        = max_q;
    if (new_max) begin
      idx_d = tag_q;
      max_d = sample;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      READ: begin
        if (rd_addr_q == LAST) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d      = FIN;
        done_d       = 1'b1;
        done_pulse_d = 1'b1;
        busy_d       = 1'b0;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      vld_q        <= 1'b0;
      tag_q        <= '0;
      idx_q        <= '0;
      max_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      vld_q        <= vld_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      max_q        <= max_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign class_idx  = idx_q;
  assign max_val    = max_q;

`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_WIDTH-1:0] sec_q, sec_d;
  logic [DATA_WIDTH:0] margin_q, margin_d;

  // runner-up tracking; margin latched as the last sample is consumed
  always_comb begin
    sec_d    = sec_q;
    margin_d = margin_q;
    if (vld_q) begin
      if (tag_q == '0) begin
        sec_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else if (sample > max_q) begin
        sec_d = max_q;
      end else if ((sample > sec_q) || (sample == max_q)) begin
        sec_d = sample;
      end
    end
    if (state_q == DRAIN) begin
      margin_d = {max_d[DATA_WIDTH-1], max_d} - {sec_d[DATA_WIDTH-1], sec_d};
    end
  end

  // runner-up and margin registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q    <= '0;
      margin_q <= '0;
    end else begin
      sec_q    <= sec_d;
      margin_q <= margin_d;
    end
  end

  assign margin = margin_q;
`else
  assign margin = '0;
`endif

endmodule

// File: tb/tb_argmax_unit.sv
// Directed bench for argmax_unit: fixed logit vectors, hand-computed results,
// latency, single done pulse, ignored restart and reset abort.
module tb_argmax_unit;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic rd_en;
  logic [IW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic busy;
  logic done;
  logic done_pulse;
  logic [IW-1:0] class_idx;
  logic signed [DW-1:0] max_val;
  logic [DW:0] margin;

  logic signed [DW-1:0] mem [N];
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int addr_log[$];

  argmax_unit #(.NUM_CLASSES(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .done_pulse(done_pulse),
    .class_idx(class_idx), .max_val(max_val), .margin(margin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (done_pulse) pulse_cnt++;
    if (rd_en) addr_log.push_back(int'(rd_addr));
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int v[N]);
    for (int i = 0; i < N; i++) mem[i] = DW'(v[i]);
  endtask

  task automatic run_scan(input int e_idx, input int e_max,
                          input int e_mar, input bit restart);
    int lat;
    int p0;
    bit seq_ok;
    lat = 0;
    p0 = pulse_cnt;
    addr_log.delete();
    start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        check("done_clr", int'(done), 0);
        check("busy_on", int'(busy), 1);
      end
      if (restart && n == 3) start = 1'b1;
      if (restart && n == 4) start = 1'b0;
      if (done_pulse) begin
        lat = n;
        break;
      end
    end
    check("latency", lat, 12);
    check("done_lvl", int'(done), 1);
    @(negedge clk);
    check("pulse_1cyc", int'(done_pulse), 0);
    check("done_hold", int'(done), 1);
    check("busy_off", int'(busy), 0);
    check("class_idx", int'(class_idx), e_idx);
    check("max_val", int'(max_val), e_max);
`ifdef ARGMAX_MARGIN_EN
    check("margin", int'(margin), e_mar);
`else
    check("margin", int'(margin), 0 * e_mar);
`endif
    seq_ok = (addr_log.size() == N);
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] != i) seq_ok = 1'b0;
    check("addr_seq", int'(seq_ok), 1);
    repeat (15) @(negedge clk);
    check("pulse_cnt", pulse_cnt - p0, 1);
    check("idx_stable", int'(class_idx), e_idx);
  endtask

  initial begin
    int v1[N] = '{3, -1, 7, 2, 0, 5, -8, 1, 6, 4};
    int v2[N] = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
    int v3[N] = '{0, 0, 0, 0, 100, 0, 0, 0, 0, 100};
    int v4[N];
    int p0;
    for (int i = 0; i < N; i++) v4[i] = -32768;
    v4[9] = 32767;
    load(v1);

    repeat (3) @(negedge clk);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'(class_idx), 0);
    check("rst_max", int'(max_val), 0);
    reset = 1'b0;
    @(negedge clk);

    run_scan(2, 7, 1, 1'b0);
    load(v2);
    run_scan(0, -5, 0, 1'b0);
    load(v3);
    run_scan(4, 100, 0, 1'b0);
    load(v4);
    run_scan(9, 32767, 65535, 1'b0);
    load(v1);
    run_scan(2, 7, 1, 1'b1);

    // abort a scan with reset during cycle t+5
    load(v3);
    p0 = pulse_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ab_rd_en", int'(rd_en), 0);
    check("ab_addr", int'(rd_addr), 0);
    check("ab_busy", int'(busy), 0);
    check("ab_done", int'(done), 0);
    check("ab_pulse", int'(done_pulse), 0);
    check("ab_idx", int'(class_idx), 0);
    check("ab_max", int'(max_val), 0);
    check("ab_margin", int'(margin), 0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("ab_no_done", pulse_cnt - p0, 0);
    check("ab_done_lo", int'(done), 0);
    load(v1);
    run_scan(2, 7, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
